adc_sram_capture: RTL and testbench

- Capture engine that writes decimated 8-bit ADC samples into the external SRAM. The 6502 later reads them back from the same SRAM.
- Sits beside tst_6502 on the shared SRAM address/data/write-strobe bus. Gains the bus through a req/gnt handshake with the top-level arbiter.
- Optional rising-edge level trigger; small FIFO absorbs bus-grant latency.

---
 rtl/adc_sram_capture.sv | 247 ++++++++++++++++++++++++
 tb/tb_adc_sram_capture.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sram_capture.sv
// Decimating, optionally triggered ADC capture into shared SRAM through a small sample FIFO.
// Samples reach the FIFO 2 clocks after adc_data; a full FIFO drops samples and sets overrun; bus_gnt stalls only the write side.

module adc_sram_fifo #(
  parameter int LOG2 = 2,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << LOG2;

  logic [W-1:0]    mem [DEPTH];
  logic [LOG2-1:0] wr_ptr, rd_ptr;
  logic [LOG2:0]   cnt;
  logic            do_push, do_pop;

  // full/empty come from the occupancy before the edge, so push and pop on one clock both land
  assign full    = cnt[LOG2];
  assign empty   = (cnt == '0);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_rdy && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{LOG2{1'b0}}, do_push} - {{LOG2{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end
endmodule

module adc_sram_capture #(
  parameter int FIFO_LOG2 = 2,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        adc_data,
  input  logic              arm,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       length,
  input  logic [7:0]        decim,
  input  logic              trig_en,
  input  logic [7:0]        trig_level,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        sram_dout,
  output logic              sram_oe,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [15:0]       wr_count
);
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [15:0]       len;
    logic [7:0]        decim;
    logic [7:0]        lvl;
  } cfg_t;

  typedef enum logic [1:0] {C_IDLE, C_WAIT_TRIG, C_RUN, C_DRAIN} cap_state_t;
  typedef enum logic [2:0] {W_IDLE, W_REQ, W_SETUP, W_STROBE, W_HOLD} wr_state_t;

  cfg_t        cfg;
  cap_state_t  cst, cst_nxt;
  wr_state_t   wst, wst_nxt;
  logic [7:0]  s1, s0;
  logic        prev_vld;
  logic [7:0]  dec_cnt;
  logic        keep, trig_hit, last_accept;
  logic [15:0] acc_cnt, wr_count_nxt;
  logic        push_vld, pop_rdy, set_done;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dat;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]  dat_q;
  logic        wr_active;

  adc_sram_fifo #(.LOG2(FIFO_LOG2), .W(8)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (arm),
    .push_vld (push_vld),
    .push_dat (s1),
    .pop_rdy  (pop_rdy),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign keep        = (dec_cnt == 8'd0);
  assign trig_hit    = keep && prev_vld && (s0 < cfg.lvl) && (s1 >= cfg.lvl);
  assign last_accept = !fifo_full && (acc_cnt == cfg.len - 16'd1);

  always_comb begin
    cst_nxt  = cst;
    push_vld = 1'b0;
    set_done = 1'b0;
    case (cst)
      C_IDLE: ;
      C_WAIT_TRIG: begin
        if (trig_hit) begin
          push_vld = 1'b1;
          cst_nxt  = last_accept ? C_DRAIN : C_RUN;
        end
      end
      C_RUN: begin
        if (keep) begin
          push_vld = 1'b1;
          if (last_accept) cst_nxt = C_DRAIN;
        end
      end
      C_DRAIN: begin
        if (fifo_empty && (wst == W_IDLE)) begin
          cst_nxt  = C_IDLE;
          set_done = 1'b1;
        end
      end
      default: cst_nxt = C_IDLE;
    endcase
    if (arm) begin
      push_vld = 1'b0;
      set_done = 1'b0;
      if (length == 16'd0) cst_nxt = C_IDLE;
      else                 cst_nxt = trig_en ? C_WAIT_TRIG : C_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cst      <= C_IDLE;
      cfg      <= '0;
      s1       <= '0;
      s0       <= '0;
      prev_vld <= 1'b0;
      dec_cnt  <= '0;
      acc_cnt  <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      cst <= cst_nxt;
      s1  <= adc_data;
      if (arm) begin
        cfg      <= '{base: base_addr, len: length, decim: decim, lvl: trig_level};
        dec_cnt  <= decim;
        prev_vld <= 1'b0;
        acc_cnt  <= '0;
        done     <= (length == 16'd0);
        overrun  <= 1'b0;
      end else begin
        if (keep) begin
          dec_cnt  <= cfg.decim;
          s0       <= s1;
          prev_vld <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt - 8'd1;
        end
        if (push_vld && !fifo_full) acc_cnt <= acc_cnt + 16'd1;
        if (push_vld && fifo_full)  overrun <= 1'b1;
        if (set_done)               done    <= 1'b1;
      end
    end
  end

  assign busy = (cst != C_IDLE);

  always_comb begin
    wst_nxt = wst;
    pop_rdy = 1'b0;
    case (wst)
      W_IDLE:   if (!fifo_empty) wst_nxt = W_REQ;
      W_REQ: begin
        if (bus_gnt && !fifo_empty) begin
          pop_rdy = 1'b1;
          wst_nxt = W_SETUP;
        end
      end
      W_SETUP:  wst_nxt = W_STROBE;
      W_STROBE: wst_nxt = W_HOLD;
      W_HOLD: begin
        // keep the grant and chain straight into the next write when data is waiting
        if (!fifo_empty) begin
          pop_rdy = 1'b1;
          wst_nxt = W_SETUP;
        end else begin
          wst_nxt = W_IDLE;
        end
      end
      default:  wst_nxt = W_IDLE;
    endcase
    if (arm) begin
      wst_nxt = W_IDLE;
      pop_rdy = 1'b0;
    end
  end

  assign wr_count_nxt = wr_count + {15'd0, (wst == W_HOLD)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wst      <= W_IDLE;
      wr_count <= '0;
      addr_q   <= '0;
      dat_q    <= '0;
    end else begin
      wst <= wst_nxt;
      if (arm) begin
        wr_count <= '0;
      end else begin
        wr_count <= wr_count_nxt;
        if (pop_rdy) begin
          addr_q <= cfg.base + ADDR_W'(wr_count_nxt);
          dat_q  <= fifo_dat;
        end
      end
    end
  end

  // address/data are zero outside a write so they combine cleanly with the CPU side
  assign wr_active = (wst == W_SETUP) || (wst == W_STROBE) || (wst == W_HOLD);
  assign addr      = wr_active ? addr_q : '0;
  assign sram_dout = wr_active ? dat_q : '0;
  assign sram_oe   = (wst == W_STROBE);
  assign bus_req   = (wst != W_IDLE);
endmodule

// File: tb/tb_adc_sram_capture.sv
// Directed bench for adc_sram_capture: reset, decimation, trigger, overrun, wrap, re-arm abort.

module tb_adc_sram_capture;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  adc_data;
  logic        arm = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] length = '0;
  logic [7:0]  decim = '0;
  logic        trig_en = 1'b0;
  logic [7:0]  trig_level = '0;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic [15:0] addr;
  logic [7:0]  sram_dout;
  logic        sram_oe;
  logic        busy;
  logic        done;
  logic        overrun;
  logic [15:0] wr_count;

  int n_chk = 0;
  int n_fail = 0;

  logic       ramp_en = 1'b0;
  logic [7:0] ramp_val = '0;
  logic [7:0] man_val = '0;
  assign adc_data = ramp_en ? ramp_val : man_val;

  adc_sram_capture #(.FIFO_LOG2(2), .ADDR_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .arm        (arm),
    .base_addr  (base_addr),
    .length     (length),
    .decim      (decim),
    .trig_en    (trig_en),
    .trig_level (trig_level),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .addr       (addr),
    .sram_dout  (sram_dout),
    .sram_oe    (sram_oe),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun),
    .wr_count   (wr_count)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1 ramp_val = ramp_val + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write log filled by the bus monitor; expected addresses come from exp_base
  logic [15:0] waddr [128];
  logic [7:0]  wdat  [128];
  int          n_wr = 0;
  int          base_idx = 0;
  logic [15:0] exp_base = '0;
  logic        p_oe = 1'b0;
  logic [15:0] p_addr = '0;
  logic        pend = 1'b0;
  logic [15:0] h_addr = '0;
  logic [15:0] ea;

  initial forever begin
    @(negedge clk);
    if (!reset) begin
      pend   = 1'b0;
      p_oe   = 1'b0;
      p_addr = '0;
    end else begin
      ea = exp_base + 16'(n_wr - base_idx);
      if (pend) begin
        check("hold_oe", sram_oe, 0);
        check("hold_addr", addr, h_addr);
        pend = 1'b0;
      end
      if (sram_oe) begin
        check("setup_oe", p_oe, 0);
        check("setup_addr", p_addr, ea);
        check("strobe_addr", addr, ea);
        if (n_wr < 128) begin
          waddr[n_wr] = addr;
          wdat[n_wr]  = sram_dout;
        end
        n_wr++;
        pend   = 1'b1;
        h_addr = ea;
      end
      p_oe   = sram_oe;
      p_addr = addr;
    end
  end

  task automatic do_arm(input logic [15:0] b, input logic [15:0] len, input logic [7:0] dec,
                        input logic te, input logic [7:0] lvl);
    base_addr  = b;
    length     = len;
    decim      = dec;
    trig_en    = te;
    trig_level = lvl;
    exp_base   = b;
    base_idx   = n_wr;
    arm        = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int i = 0;
    while (!done && i < max) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int idx;
  logic [7:0] step;

  initial begin
    #12;
    check("rst_oe", sram_oe, 0);
    check("rst_req", bus_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", wr_count, 0);
    check("rst_addr", addr, 0);
    check("rst_dout", sram_dout, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // length 0 finishes on the next clock without touching the bus
    do_arm(16'h0100, 16'd0, 8'd0, 1'b0, 8'd0);
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("len0_req", bus_req, 0);
    end

    // ramp, decim 3: four writes spaced by 4
    bus_gnt = 1'b1;
    ramp_en = 1'b1;
    do_arm(16'h1000, 16'd4, 8'd3, 1'b0, 8'd0);
    check("ramp_busy", busy, 1);
    check("ramp_done0", done, 0);
    wait_done("ramp_done", 200);
    check("ramp_nwr", n_wr - base_idx, 4);
    check("ramp_cnt", wr_count, 4);
    check("ramp_ovr", overrun, 0);
    check("ramp_busy_end", busy, 0);
    check("ramp_a0", waddr[base_idx], 16'h1000);
    check("ramp_a3", waddr[base_idx+3], 16'h1003);
    for (int i = 0; i < 3; i++) begin
      step = wdat[base_idx+i+1] - wdat[base_idx+i];
      check("ramp_step", step, 4);
    end

    // rising-edge trigger at 0x80
    ramp_en = 1'b0;
    man_val = 8'h10;
    repeat (3) @(posedge clk);
    #1;
    do_arm(16'h4000, 16'd2, 8'd0, 1'b1, 8'h80);
    repeat (8) @(posedge clk);
    #1;
    check("trig_nowr", n_wr - base_idx, 0);
    check("trig_wait_req", bus_req, 0);
    man_val = 8'h90;
    wait_done("trig_done", 100);
    check("trig_nwr", n_wr - base_idx, 2);
    check("trig_d0", wdat[base_idx], 8'h90);
    check("trig_d1", wdat[base_idx+1], 8'h90);
    check("trig_a0", waddr[base_idx], 16'h4000);
    check("trig_cnt", wr_count, 2);

    // grant withheld: FIFO overflows, capture still completes
    ramp_en = 1'b1;
    bus_gnt = 1'b0;
    do_arm(16'h2000, 16'd16, 8'd0, 1'b0, 8'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) begin
        check("ovr_req", bus_req, 1);
        check("ovr_oe", sram_oe, 0);
        check("ovr_flag", overrun, 1);
      end
    end
    bus_gnt = 1'b1;
    wait_done("ovr_done", 400);
    check("ovr_cnt", wr_count, 16);
    check("ovr_nwr", n_wr - base_idx, 16);
    check("ovr_sticky", overrun, 1);

    // address wrap
    do_arm(16'hFFFE, 16'd3, 8'd2, 1'b0, 8'd0);
    check("wrap_ovr_clr", overrun, 0);
    wait_done("wrap_done", 200);
    check("wrap_a0", waddr[base_idx], 16'hFFFE);
    check("wrap_a1", waddr[base_idx+1], 16'hFFFF);
    check("wrap_a2", waddr[base_idx+2], 16'h0000);
    check("wrap_cnt", wr_count, 3);

    // re-arm mid-capture
    do_arm(16'h3000, 16'd8, 8'd3, 1'b0, 8'd0);
    idx = 0;
    while (wr_count != 16'd2 && idx < 200) begin
      @(posedge clk);
      #1;
      idx++;
    end
    check("abort_reach2", wr_count, 2);
    do_arm(16'h5000, 16'd2, 8'd3, 1'b0, 8'd0);
    check("abort_oe", sram_oe, 0);
    check("abort_req", bus_req, 0);
    check("abort_cnt", wr_count, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 1);
    wait_done("abort_done2", 200);
    check("abort_nwr", n_wr - base_idx, 2);
    check("abort_a0", waddr[base_idx], 16'h5000);
    check("abort_a1", waddr[base_idx+1], 16'h5001);
    check("abort_cnt2", wr_count, 2);

    // asynchronous reset during the strobe
    do_arm(16'h6000, 16'd4, 8'd0, 1'b0, 8'd0);
    idx = 0;
    while (!sram_oe && idx < 50) begin
      @(posedge clk);
      #1;
      idx++;
    end
    check("mid_strobe", sram_oe, 1);
    reset = 1'b0;
    #1;
    check("mid_oe", sram_oe, 0);
    check("mid_req", bus_req, 0);
    check("mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_busy", busy, 0);
    check("post_req", bus_req, 0);
    check("post_done", done, 0);
    check("post_cnt", wr_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
